// File: rtl/sdu_mem.sv
// sdu_mem: UART memory debug unit.
// Host commands over 8N1 serial: 'R' read one word, 'W' write one word,
// 'D' dump N words, anything else answered with '?'.
// Multi-byte fields are big-endian; the memory port expects asynchronous-read RAM.
module sdu_mem #(
    parameter int unsigned BAUD_DIV    = 868,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 34720
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic              txd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned AB  = (ADDR_W + 7) / 8;
    localparam int unsigned DB  = DATA_W / 8;
    localparam int unsigned AW8 = 8 * AB;
    localparam int unsigned BCW = $clog2(BAUD_DIV);
    localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BCW-1:0] BaudLast = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0] BaudMid  = BCW'(BAUD_DIV / 2 - 1);
    localparam logic [TOW-1:0] ToLast   = TOW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     AbLast   = 4'(AB - 1);
    localparam logic [3:0]     DbLast   = 4'(DB - 1);

    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdDump  = 8'h44;
    localparam logic [7:0] RespOk   = 8'h4B;
    localparam logic [7:0] RespBad  = 8'h3F;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e      rx_st;
    logic           rx_s1, rx_s2;
    logic [BCW-1:0] rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_sh;
    logic           rx_done;
    logic           rx_ferr;

    assign rx_done = (rx_st == RxStop) && (rx_cnt == BaudLast) && rx_s2;
    assign rx_ferr = (rx_st == RxStop) && (rx_cnt == BaudLast) && !rx_s2;

    // Two-flop synchroniser for the asynchronous rxd pin
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    // Receive bit sequencer: validate start at mid-bit, sample data and stop at mid-bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_st  <= RxIdle;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                RxIdle: begin
                    rx_cnt <= '0;
                    if (!rx_s2) rx_st <= RxStart;
                end
                RxStart: begin
                    if (rx_cnt == BaudMid) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        // A glitch that is high again at mid-bit is not a start bit
                        rx_st  <= rx_s2 ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt == BaudLast) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_st <= RxStop;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt == BaudLast) begin
                        rx_cnt <= '0;
                        rx_st  <= RxIdle;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_st <= RxIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic           tx_active;
    logic [BCW-1:0] tx_cnt;
    logic [3:0]     tx_bit;
    logic [8:0]     tx_sh;
    logic           tx_load;
    logic [7:0]     tx_byte;
    logic           tx_stop;
    logic           tx_ready;

    // tx_ready is also true in the final stop-bit cycle so a new byte can follow with no gap
    assign tx_stop  = tx_active && (tx_bit == 4'd9);
    assign tx_ready = !tx_active || (tx_stop && (tx_cnt == BaudLast));

    // Transmit shifter: bit 0 is the start bit, bit 9 the stop bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txd       <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '1;
        end else if (tx_load) begin
            txd       <= 1'b0;
            tx_sh     <= {1'b1, tx_byte};
            tx_bit    <= '0;
            tx_cnt    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_cnt == BaudLast) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    txd    <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle, StGetAddr, StGetData, StGetCnt, StMemRd, StMemWr, StSend, StAck
    } state_e;

    state_e            state;
    logic [7:0]        cmd_q;
    logic [3:0]        byte_cnt;
    logic [AW8-1:0]    addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] word_q;
    logic [3:0]        bytes_left;
    logic [8:0]        words_left;
    logic [TOW-1:0]    idle_cnt;

    logic [AW8-1:0]    addr_asm;
    logic [DATA_W-1:0] data_asm;
    logic              in_get;
    logic              timeout;
    logic              cmd_known;

    assign addr_asm  = (addr_sh << 8) | AW8'(rx_sh);
    assign data_asm  = (data_sh << 8) | DATA_W'(rx_sh);
    assign in_get    = (state == StGetAddr) || (state == StGetData) || (state == StGetCnt);
    assign timeout   = in_get && !rx_done && (idle_cnt == ToLast);
    assign cmd_known = (rx_sh == CmdRead) || (rx_sh == CmdWrite) || (rx_sh == CmdDump);

    // Byte handed to the transmitter; asserted only while it can accept one
    always_comb begin
        tx_load = 1'b0;
        tx_byte = 8'h00;
        case (state)
            StIdle: begin
                if (rx_done && !cmd_known) begin
                    tx_load = 1'b1;
                    tx_byte = RespBad;
                end
            end
            StMemWr: begin
                tx_load = 1'b1;
                tx_byte = RespOk;
            end
            StMemRd: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = mem_rdata[DATA_W-1 -: 8];
                end
            end
            StSend: begin
                if (tx_ready && (bytes_left != 4'd0)) begin
                    tx_load = 1'b1;
                    tx_byte = word_q[DATA_W-1 -: 8];
                end
            end
            default: ;
        endcase
    end

    // Parser FSM with registered memory-port and busy outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            cmd_q      <= '0;
            byte_cnt   <= '0;
            addr_sh    <= '0;
            data_sh    <= '0;
            word_q     <= '0;
            bytes_left <= '0;
            words_left <= '0;
            idle_cnt   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (in_get && !rx_done) idle_cnt <= idle_cnt + 1'b1;
            else                    idle_cnt <= '0;

            if (in_get && (rx_ferr || timeout)) begin
                // Abandon the partial command without replying
                state <= StIdle;
                busy  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (rx_done) begin
                            busy     <= 1'b1;
                            cmd_q    <= rx_sh;
                            byte_cnt <= '0;
                            state    <= cmd_known ? StGetAddr : StAck;
                        end
                    end
                    StGetAddr: begin
                        if (rx_done) begin
                            addr_sh  <= addr_asm;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == AbLast) begin
                                mem_addr <= addr_asm[ADDR_W-1:0];
                                byte_cnt <= '0;
                                if (cmd_q == CmdWrite) begin
                                    state <= StGetData;
                                end else if (cmd_q == CmdDump) begin
                                    state <= StGetCnt;
                                end else begin
                                    words_left <= 9'd1;
                                    state      <= StMemRd;
                                end
                            end
                        end
                    end
                    StGetData: begin
                        if (rx_done) begin
                            data_sh  <= data_asm;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == DbLast) begin
                                mem_wdata <= data_asm;
                                mem_we    <= 1'b1;
                                state     <= StMemWr;
                            end
                        end
                    end
                    StGetCnt: begin
                        if (rx_done) begin
                            // A count of zero stands for a full 256-word dump
                            words_left <= (rx_sh == 8'h00) ? 9'd256 : {1'b0, rx_sh};
                            state      <= StMemRd;
                        end
                    end
                    StMemRd: begin
                        // Capture waits for the previous word's stop bit to finish
                        if (tx_ready) begin
                            word_q     <= mem_rdata << 8;
                            bytes_left <= DbLast;
                            words_left <= words_left - 1'b1;
                            state      <= StSend;
                        end
                    end
                    StSend: begin
                        if (bytes_left != 4'd0) begin
                            if (tx_ready) begin
                                word_q     <= word_q << 8;
                                bytes_left <= bytes_left - 1'b1;
                            end
                        end else if (words_left != 9'd0) begin
                            // Fetch the next dump word while the last stop bit is on the line
                            if (tx_stop) begin
                                mem_addr <= mem_addr + 1'b1;
                                state    <= StMemRd;
                            end
                        end else if (tx_ready) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    StMemWr: state <= StAck;
                    StAck: begin
                        if (tx_ready) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdu_mem.sv
// Directed testbench for sdu_mem: UART host model, RAM model and reply monitor.
module tb_sdu_mem;

    localparam int unsigned BAUD = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sdu_mem #(
        .BAUD_DIV   (BAUD),
        .ADDR_W     (8),
        .DATA_W     (32),
        .TIMEOUT_CYC(400)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .txd      (txd),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with a preload port and a record of write strobes
    logic [31:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          we_count = 0;
    logic [7:0]  we_addr = '0;
    logic [31:0] we_data = '0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_count      <= we_count + 1;
            we_addr       <= mem_addr;
            we_data       <= mem_wdata;
        end
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Reply monitor: decodes txd bytes and notes the cycle each start bit was seen
    logic [7:0] rx_q[$];
    int         t_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                logic [7:0] b;
                int         t0;
                t0 = cyc;
                b  = '0;
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BAUD) @(negedge clk);
                rx_q.push_back(b);
                t_q.push_back(t0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rxd = stop;
        repeat (BAUD) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        t_q.delete();
    endtask

    task automatic wait_rx(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic wait_busy_low(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, required 1", txd); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", mem_we); end
        n_tests++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h, required 00", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", mem_wdata); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic ok;
        int   w0;
        clear_mon();
        w0 = we_count;
        send_byte(8'h57, 1'b1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_rise: got %b, required 1", busy); end
        send_byte(8'h10, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_rx(1, 400, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL write_reply_wait: got %0d bytes, required 1", rx_q.size()); end
        n_tests++; if (rx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL write_reply: got %h, required 4b", rx_q[0]); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_in_stop: got %b, required 1", busy); end
        wait_busy_low(40, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL write_busy_fall: got %b, required 0", busy); end
        n_tests++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL write_we_count: got %0d, required 1", we_count - w0); end
        n_tests++; if (we_addr !== 8'h10) begin n_fail++; $display("FAIL write_addr: got %h, required 10", we_addr); end
        n_tests++; if (we_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_data: got %h, required deadbeef", we_data); end
    endtask

    task automatic test_read();
        logic       ok;
        logic [7:0] exp_q[$];
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        preload(8'h10, 32'hDEADBEEF);
        clear_mon();
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_rx(4, 800, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_wait: got %0d bytes, required 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL read_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
        end
        n_tests++;
        if (t_q[3] - t_q[0] !== 30 * BAUD) begin
            n_fail++; $display("FAIL read_spacing: got %0d cycles, required %0d", t_q[3] - t_q[0], 30 * BAUD);
        end
        wait_busy_low(40, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_busy_fall: got %b, required 0", busy); end
    endtask

    task automatic test_dump();
        logic       ok;
        logic [7:0] exp_q[$];
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h00, 8'h00, 8'h00, 8'h03};
        preload(8'hFE, 32'h1);
        preload(8'hFF, 32'h2);
        preload(8'h00, 32'h3);
        clear_mon();
        send_byte(8'h44, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h03, 1'b1);
        wait_rx(12, 2000, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dump_wait: got %0d bytes, required 12", rx_q.size()); end
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dump_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
        end
        n_tests++;
        if (t_q[11] - t_q[0] !== 110 * BAUD) begin
            n_fail++; $display("FAIL dump_spacing: got %0d cycles, required %0d", t_q[11] - t_q[0], 110 * BAUD);
        end
        wait_busy_low(40, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dump_busy_fall: got %b, required 0", busy); end
    endtask

    task automatic test_unknown();
        logic       ok;
        logic [7:0] exp_q[$];
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h03};
        clear_mon();
        send_byte(8'h41, 1'b1);
        wait_rx(1, 400, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL unknown_wait: got %0d bytes, required 1", rx_q.size()); end
        n_tests++; if (rx_q[0] !== 8'h3F) begin n_fail++; $display("FAIL unknown_reply: got %h, required 3f", rx_q[0]); end
        wait_busy_low(40, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL unknown_busy_fall: got %b, required 0", busy); end
        clear_mon();
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_rx(4, 800, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL recover_wait: got %0d bytes, required 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL recover_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
        end
        wait_busy_low(40, ok);
    endtask

    task automatic test_timeout();
        logic       ok;
        int         w0;
        logic [7:0] exp_q[$];
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        preload(8'h20, 32'h12345678);
        clear_mon();
        w0 = we_count;
        send_byte(8'h57, 1'b1);
        send_byte(8'h20, 1'b1);
        repeat (300) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got busy %b, required 1", busy); end
        repeat (200) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b, required 0", busy); end
        n_tests++; if (we_count !== w0) begin n_fail++; $display("FAIL timeout_we: got %0d strobes, required 0", we_count - w0); end
        n_tests++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL timeout_reply: got %0d bytes, required 0", rx_q.size()); end
        send_byte(8'h52, 1'b1);
        send_byte(8'h20, 1'b1);
        wait_rx(4, 800, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timeout_next_wait: got %0d bytes, required 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_next_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
        end
        wait_busy_low(40, ok);
    endtask

    task automatic test_framing();
        logic       ok;
        logic [7:0] exp_q[$];
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_mon();
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b0);
        repeat (150) @(negedge clk);
        n_tests++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL framing_reply: got %0d bytes, required 0", rx_q.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy: got %b, required 0", busy); end
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_rx(4, 800, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL framing_next_wait: got %0d bytes, required 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL framing_next_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
        end
        wait_busy_low(40, ok);
    endtask

    task automatic test_reset_mid_dump();
        logic ok;
        clear_mon();
        send_byte(8'h44, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_rx(2, 800, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL middump_wait: got %0d bytes, required 2", rx_q.size()); end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (txd === 1'b0) ok = 1'b1;
        end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL middump_txd_low: got %b, required 0", txd); end
        rstn = 1'b0;
        #1;
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL middump_txd: got %b, required 1", txd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL middump_busy: got %b, required 0", busy); end
        n_tests++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL middump_addr: got %h, required 00", mem_addr); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL middump_after_busy: got %b, required 0", busy); end
        n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL middump_after_txd: got %b, required 1", txd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_dump();
        test_unknown();
        test_timeout();
        test_framing();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
